load_align_unit: RTL and testbench
==================================

// Module: load_align_unit
// PURPOSE
//   Registered load-data formatter for the MEM stage. Accepts one load request
//   (address, size, signedness, dest reg tag) and issues word-aligned reads to a
//   1-cycle synchronous data memory. Extracts and sign/zero-extends byte, half
//   or word results and returns them to WB over a valid/ready handshake.
//   Misaligned loads either split into two reads or raise an address error.
// PARAMETERS
//   DATA_W  32  memory word width; power of 2, >=16; BYTES=DATA_W/8, OFF_W=log2(BYTES)
//   ADDR_W  32  byte address width
//   SIZE_W  2   width of req_size; access is 2**req_size bytes
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active-high
//   req_valid  in   1       load request present
//   req_ready  out  1       unit idle and can accept (high only in IDLE)
//   req_addr   in   ADDR_W  byte address
//   req_size   in   SIZE_W  0=byte 1=half 2=word ... OFF_W=full word; >OFF_W reserved
//   req_signed in   1       1=sign-extend, 0=zero-extend
//   req_rd     in   5       destination register tag, returned unchanged
//   mem_rd_en  out  1       registered read strobe
//   mem_addr   out  ADDR_W  registered word-aligned address (low OFF_W bits 0)
//   mem_rdata  in   DATA_W  valid in the cycle after mem_rd_en is high
//   out_valid  out  1       result valid; held until out_ready
//   out_ready  in   1       WB accepts the result
//   out_data   out  DATA_W  extended load result
//   out_rd     out  5       tag of the result
//   addr_err   out  1       qualifies out_valid; misaligned or reserved size
// BEHAVIOUR
//   - Little-endian: byte k of a word is mem_rdata[8k+7:8k]; off=req_addr[OFF_W-1:0].
//   - FSM: IDLE -> RD0 -> DAT0 -> [RD1 -> DAT1] -> OUT -> IDLE.
//   - Accept on req_valid&req_ready (cycle 0): latch all req fields. mem_rd_en=1 and
//     mem_addr=aligned addr in cycle 1 (RD0). mem_rdata is captured at end of cycle 2
//     (DAT0). out_valid=1 from cycle 3 (OUT). One memory read per aligned load.
//   - Misaligned: off not a multiple of 2**size. Cross: off+2**size > BYTES.
//   - Split load: mem_rd_en in cycle 3 at aligned+BYTES (mod 2**ADDR_W; top address
//     wraps to 0). Second word captured end of cycle 4, out_valid from cycle 5.
//     Result = low 2**size bytes of ({word1,word0} >> 8*off), then extended.
//   - Extension: bits above 8*2**size take the result MSB if req_signed, else 0.
//     Full-word loads ignore req_signed.
//   - Reserved size: no memory read; OUT in cycle 1, addr_err=1, out_data=0.
//   - OUT: out_valid, out_data, out_rd and addr_err stay stable until out_ready.
//     out_valid&out_ready returns the FSM to IDLE, so req_ready=1 in the next cycle.
//     No overlap between requests; req_valid outside IDLE is ignored.
//   - mem_rd_en is high for exactly one cycle per read and is 0 in every other state.
//   - Reset: state=IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, out_valid=0,
//     out_data=0, out_rd=0, addr_err=0. Reset mid-operation abandons the load with
//     no out_valid. mem_rdata from a read still in flight is ignored.
// CONFIGURATION
//   LOAD_SPLIT_EN defined: a misaligned non-crossing load does a single read. A
//     crossing load is split as above. addr_err is raised only for a reserved size.
//   LOAD_SPLIT_EN undefined: any misaligned load does no memory read. It goes to
//     OUT in cycle 1 with addr_err=1 and out_data=0. RD1/DAT1 are not built.
// TESTING (DATA_W=32)
//   1 LW 0x100, rdata 0x8899AABB -> mem_rd_en cycle 1 only; out_data 0x8899AABB,
//     out_valid cycle 3, addr_err 0, out_rd echoed.
//   2 LB 0x103, rdata 0x80FF7F01: signed -> 0xFFFFFF80; unsigned -> 0x00000080.
//   3 LH 0x102, rdata 0x80011234: signed -> 0xFFFF8001; unsigned -> 0x00008001.
//   4 [LOAD_SPLIT_EN] LW 0x102, 0x100=0x11112222, 0x104=0x33334444 -> reads in
//     cycles 1 and 3, out 0x44441111 in cycle 5. LW 0xFFFFFFFE -> second read at 0x0.
//   5 [no LOAD_SPLIT_EN] LH 0x101 -> mem_rd_en never high; out_valid cycle 1,
//     addr_err 1, data 0. req_size=3 -> same in both builds.
//   6 out_ready low 3 cycles -> outputs held, req_ready 0. rst in cycle 2 of a split
//     -> no out_valid, mem_rd_en 0 next cycle, req_ready 1 after reset.

Source files
------------

// File: rtl/load_align_unit.sv
// load_align_unit: MEM-stage load formatter issuing word-aligned reads to a 1-cycle memory.
// Optional macro LOAD_SPLIT_EN splits line-crossing misaligned loads into two reads.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_signed,
  input  logic [4:0]        req_rd,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              addr_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, RD0, DAT0, RD1, DAT1, OUT} state_t;
  state_t state_reg, state_next;

  logic [OFF_W-1:0]  off_reg;
  logic [SIZE_W-1:0] size_reg;
  logic              signed_reg;
  logic [4:0]        rd_reg;
`ifdef LOAD_SPLIT_EN
  logic              split_reg;
  logic [DATA_W-1:0] word0_reg;
  logic              req_cross;
`else
  logic              req_misaligned;
`endif
  logic [OFF_W-1:0]    req_off;
  logic [31:0]         req_bytes;
  logic                req_reserved;
  logic                req_error;
  logic [DATA_W-1:0]   fmt_lo;
  logic [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]   raw_data;
  logic [DATA_W-1:0]   ext_data;
  logic [IDX_W-1:0]    msb_idx;
  int                  ext_bits;
  logic                ext_fill;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Request classification, evaluated while idle
  always_comb begin
    req_off      = req_addr[OFF_W-1:0];
    req_bytes    = 32'd1 << req_size;
    req_reserved = 32'(req_size) > 32'(OFF_W);
`ifdef LOAD_SPLIT_EN
    req_cross    = !req_reserved && ((32'(req_off) + req_bytes) > 32'(BYTES));
    req_error    = req_reserved;
`else
    req_misaligned = (32'(req_off) & (req_bytes - 32'd1)) != 32'd0;
    req_error      = req_reserved || req_misaligned;
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = req_error ? OUT : RD0;
      RD0:     state_next = DAT0;
`ifdef LOAD_SPLIT_EN
      DAT0:    state_next = split_reg ? RD1 : OUT;
      RD1:     state_next = DAT1;
      DAT1:    state_next = OUT;
`else
      DAT0:    state_next = OUT;
`endif
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs and the extraction datapath; the high word is always the word arriving now
  always_comb begin
    req_ready = (state_reg == IDLE);
`ifdef LOAD_SPLIT_EN
    fmt_lo    = (state_reg == DAT1) ? word0_reg : mem_rdata;
`else
    fmt_lo    = mem_rdata;
`endif
    shifted   = {mem_rdata, fmt_lo} >> {off_reg, 3'b000};
    raw_data  = shifted[DATA_W-1:0];
    ext_bits  = (32'(size_reg) >= 32'(OFF_W)) ? DATA_W : (8 << size_reg);
    msb_idx   = IDX_W'(ext_bits - 1);
    ext_fill  = signed_reg && raw_data[msb_idx];
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    assign ext_data[gi] = (gi < ext_bits) ? raw_data[gi] : ext_fill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      addr_err   <= 1'b0;
      off_reg    <= '0;
      size_reg   <= '0;
      signed_reg <= 1'b0;
      rd_reg     <= '0;
`ifdef LOAD_SPLIT_EN
      split_reg  <= 1'b0;
      word0_reg  <= '0;
`endif
    end else begin
      mem_rd_en <= (state_next == RD0) || (state_next == RD1);
      out_valid <= (state_next == OUT);
      if (state_reg == IDLE && req_valid) begin
        off_reg    <= req_off;
        size_reg   <= req_size;
        signed_reg <= req_signed;
        rd_reg     <= req_rd;
        mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef LOAD_SPLIT_EN
        split_reg  <= req_cross;
`endif
      end
`ifdef LOAD_SPLIT_EN
      if (state_reg == DAT0) word0_reg <= mem_rdata;
      if (state_next == RD1) mem_addr <= mem_addr + ADDR_W'(BYTES);
`endif
      // Entering OUT straight from IDLE only happens for a rejected request
      if (state_next == OUT && state_reg != OUT) begin
        out_rd   <= (state_reg == IDLE) ? req_rd : rd_reg;
        addr_err <= (state_reg == IDLE);
        out_data <= (state_reg == IDLE) ? '0 : ext_data;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed load table against a behavioural 1-cycle memory,
// plus hand-written back-pressure and mid-load reset sequences.
`timescale 1ns/1ps
module tb_load_align_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [4:0]  req_rd;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_a0, cur_a1, cur_w0, cur_w1;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SIZE_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_rd(req_rd),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .addr_err(addr_err)
  );

  // One-cycle synchronous memory; junk whenever no read was issued
  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rdata <= (mem_addr == cur_a0) ? cur_w0 :
                   (mem_addr == cur_a1) ? cur_w1 : 32'hDEADBEEF;
    else
      mem_rdata <= 32'h5A5A5A5A;
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  rd;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [15:0] exp_mask;
    int          exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                              input logic [4:0] rd, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] exp_data, input logic exp_err,
                              input logic [15:0] exp_mask, input int exp_out);
    vec_t v;
    v.addr = addr; v.size = size; v.sgn = sgn; v.rd = rd; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.exp_data = exp_data; v.exp_err = exp_err;
    v.exp_mask = exp_mask; v.exp_out = exp_out;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input int hold);
    logic [15:0] mask;
    int          first_out;
    int          nrd;
    mask = '0; first_out = 0; nrd = 0;
    cur_a0 = v.a0; cur_a1 = v.a1; cur_w0 = v.w0; cur_w1 = v.w1;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = v.addr; req_size = v.size; req_signed = v.sgn; req_rd = v.rd;
    for (int c = 1; c <= 12 && first_out == 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      if (mem_rd_en) begin
        mask[c] = 1'b1;
        if (nrd == 0) check("rd_addr0", mem_addr, v.a0);
        else          check("rd_addr1", mem_addr, v.a1);
        nrd++;
      end
      if (out_valid) first_out = c;
    end
    check("out_valid_cycle", 32'(first_out), 32'(v.exp_out));
    if (first_out == 0) return;
    check("rd_strobe_cycles", 32'(mask), 32'(v.exp_mask));
    check("out_data", out_data, v.exp_data);
    check("out_rd", 32'(out_rd), 32'(v.rd));
    check("addr_err", 32'(addr_err), 32'(v.exp_err));
    // Back-pressure: a new request presented meanwhile must be ignored
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_addr = 32'h0000_0040; req_size = 2'd2; req_rd = 5'd30;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, v.exp_data);
      check("hold_rd", 32'(out_rd), 32'(v.rd));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_no_read", 32'(mem_rd_en), 32'd0);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_hs_valid", 32'(out_valid), 32'd0);
    check("after_hs_ready", 32'(req_ready), 32'd1);
    $display("txn %0d addr=0x%08h size=%0d sgn=%0d -> data=0x%08h err=%0d rd=%0d cyc=%0d",
             idx, v.addr, v.size, v.sgn, out_data, addr_err, out_rd, first_out);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
    req_rd = '0; out_ready = 1'b0;
    cur_a0 = '0; cur_a1 = '0; cur_w0 = '0; cur_w1 = '0;

    vecs.push_back(mk(32'h100, 2'd2, 1'b0, 5'd5,  32'h8899AABB, 32'h0, 32'h100, 32'h104, 32'h8899AABB, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h103, 2'd0, 1'b1, 5'd1,  32'h80FF7F01, 32'h0, 32'h100, 32'h104, 32'hFFFFFF80, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h103, 2'd0, 1'b0, 5'd2,  32'h80FF7F01, 32'h0, 32'h100, 32'h104, 32'h00000080, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h102, 2'd1, 1'b1, 5'd3,  32'h80011234, 32'h0, 32'h100, 32'h104, 32'hFFFF8001, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h102, 2'd1, 1'b0, 5'd4,  32'h80011234, 32'h0, 32'h100, 32'h104, 32'h00008001, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h101, 2'd0, 1'b1, 5'd6,  32'h80FF7F01, 32'h0, 32'h100, 32'h104, 32'h0000007F, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h102, 2'd0, 1'b1, 5'd7,  32'h80FF7F01, 32'h0, 32'h100, 32'h104, 32'hFFFFFFFF, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h100, 2'd1, 1'b1, 5'd8,  32'h80011234, 32'h0, 32'h100, 32'h104, 32'h00001234, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h204, 2'd2, 1'b1, 5'd31, 32'h80000000, 32'h0, 32'h204, 32'h208, 32'h80000000, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h100, 2'd3, 1'b1, 5'd9,  32'h12345678, 32'h0, 32'h100, 32'h104, 32'h00000000, 1'b1, 16'h0000, 1));
`ifdef LOAD_SPLIT_EN
    vecs.push_back(mk(32'h102,      2'd2, 1'b0, 5'd10, 32'h11112222, 32'h33334444, 32'h100,      32'h104, 32'h44441111, 1'b0, 16'h000A, 5));
    vecs.push_back(mk(32'hFFFFFFFE, 2'd2, 1'b0, 5'd11, 32'hAABBCCDD, 32'h11223344, 32'hFFFFFFFC, 32'h000, 32'h3344AABB, 1'b0, 16'h000A, 5));
    vecs.push_back(mk(32'h101,      2'd1, 1'b1, 5'd12, 32'h12F0AB34, 32'h0,        32'h100,      32'h104, 32'hFFFFF0AB, 1'b0, 16'h0002, 3));
    vecs.push_back(mk(32'h103,      2'd1, 1'b1, 5'd13, 32'h80FF7F01, 32'h000000C3, 32'h100,      32'h104, 32'hFFFFC380, 1'b0, 16'h000A, 5));
    vecs.push_back(mk(32'h101,      2'd2, 1'b0, 5'd14, 32'h11223344, 32'h55667788, 32'h100,      32'h104, 32'h88112233, 1'b0, 16'h000A, 5));
`else
    vecs.push_back(mk(32'h101, 2'd1, 1'b1, 5'd10, 32'h12F0AB34, 32'h0, 32'h100, 32'h104, 32'h00000000, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(32'h102, 2'd2, 1'b0, 5'd11, 32'h11112222, 32'h0, 32'h100, 32'h104, 32'h00000000, 1'b1, 16'h0000, 1));
    vecs.push_back(mk(32'h103, 2'd1, 1'b0, 5'd12, 32'h80FF7F01, 32'h0, 32'h100, 32'h104, 32'h00000000, 1'b1, 16'h0000, 1));
`endif

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(i, vecs[i], (i == 1) ? 3 : 0);

    // Reset during cycle 2 of a load: abandoned with no result and no further read
    @(negedge clk);
`ifdef LOAD_SPLIT_EN
    cur_a0 = 32'h100; cur_a1 = 32'h104; cur_w0 = 32'h11112222; cur_w1 = 32'h33334444;
    req_addr = 32'h102;
`else
    cur_a0 = 32'h100; cur_a1 = 32'h104; cur_w0 = 32'h8899AABB; cur_w1 = 32'h0;
    req_addr = 32'h100;
`endif
    req_valid = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_seq_read_c1", 32'(mem_rd_en), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_seq_no_read", 32'(mem_rd_en), 32'd0);
    check("rst_seq_no_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_seq_ready", 32'(req_ready), 32'd1);
      check("rst_seq_valid_quiet", 32'(out_valid), 32'd0);
      check("rst_seq_read_quiet", 32'(mem_rd_en), 32'd0);
    end
    $display("txn reset-abandon addr=0x%08h done", req_addr);

    // A fresh load after the abandoned one still completes normally
    run_vec(100, vecs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
